// File: rtl/bt_uart_tx_arbiter.sv
// 8N1 UART transmitter shared by NUM_REQ byte streams through a packet-locking
// round-robin arbiter; an owner keeps the line until its last byte or a lock timeout.
module bt_uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned LOCK_TIMEOUT = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 uart_txd
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned TO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [IDX_W-1:0]  rr;
    logic [IDX_W-1:0]  owner;
    logic [TO_W-1:0]   to_cnt;

    logic               locked;
    logic               found;
    logic               accept;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic [7:0]         win_data;
    logic               win_last;
    int                 j;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (32'(i) == NUM_REQ - 1) return '0;
        return i + 1'b1;
    endfunction

    assign locked = |grant;

    // A locked owner is offered ready even while it is not yet valid.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        j       = 0;
        if (locked) begin
            win_oh  = grant;
            win_idx = owner;
        end else begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                j = int'(rr) + k;
                if (j >= int'(NUM_REQ)) j = j - int'(NUM_REQ);
                cand = IDX_W'(j);
                if (!found && req_valid[cand]) begin
                    found         = 1'b1;
                    win_oh[cand]  = 1'b1;
                    win_idx       = cand;
                end
            end
        end
        win_data  = req_data[8*win_idx +: 8];
        win_last  = req_last[win_idx];
        req_ready = (state == StIdle) ? win_oh : '0;
        accept    = |(req_valid & req_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rr       <= '0;
            owner    <= '0;
            to_cnt   <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        shift    <= win_data;
                        state    <= StStart;
                        baud_cnt <= '0;
                        busy     <= 1'b1;
                        uart_txd <= 1'b0;
                        to_cnt   <= '0;
                        if (win_last) begin
                            grant <= '0;
                            rr    <= next_idx(win_idx);
                        end else begin
                            grant <= win_oh;
                            owner <= win_idx;
                        end
                    end else if (locked && !req_valid[owner]) begin
                        if (to_cnt == TO_LAST) begin
                            grant  <= '0;
                            rr     <= next_idx(owner);
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end else begin
                        to_cnt <= '0;
                    end
                end
                StStart: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= StData;
                        uart_txd <= shift[0];
                        shift    <= shift >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state    <= StStop;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            uart_txd <= shift[0];
                            shift    <= shift >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= StIdle;
                        busy     <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bt_uart_tx_arbiter.sv
// Bench for bt_uart_tx_arbiter: a timeline model of frames and arbitration checked every
// cycle, plus directed scenarios with hand-computed accept orders, gaps and line bits.
module tb_bt_uart_tx_arbiter;

    localparam int N   = 2;
    localparam int CPB = 4;
    localparam int LT  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           uart_txd;

    bt_uart_tx_arbiter #(
        .NUM_REQ     (N),
        .CLKS_PER_BIT(CPB),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .grant    (grant),
        .busy     (busy),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // DUT-observed accepts, for the directed expectations.
    int         acc_cyc[$];
    int         acc_idx[$];
    logic [7:0] acc_byte[$];

    // Model: a frame is a time window; arbitration is owner / rr / idle-lock counter.
    bit         m_on = 0;
    int         m_start = 0;
    logic [7:0] m_byte = '0;
    int         m_owner = -1;
    int         m_rr = 0;
    int         m_tcnt = 0;

    bit         in_fr;
    int         kbit;
    int         w;
    int         aw;
    logic       e_txd;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_grant;

    always @(negedge clk) begin
        in_fr = m_on && (cyc >= m_start) && (cyc < m_start + 10 * CPB);
        e_txd = 1'b1;
        if (in_fr) begin
            kbit = (cyc - m_start) / CPB;
            if (kbit == 0) e_txd = 1'b0;
            else if (kbit <= 8) e_txd = m_byte[kbit-1];
        end
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        e_ready = '0;
        if (!in_fr) begin
            if (m_owner >= 0) begin
                e_ready = e_grant;
            end else begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
                if (w >= 0) e_ready[w] = 1'b1;
            end
        end
        check("m_txd", uart_txd, e_txd);
        check("m_busy", busy, in_fr);
        check("m_grant", grant, e_grant);
        check("m_ready", req_ready, e_ready);

        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc_cyc.push_back(cyc);
                acc_idx.push_back(i);
                acc_byte.push_back(req_data[8*i +: 8]);
            end
        end

        if (reset) begin
            m_on = 0; m_owner = -1; m_rr = 0; m_tcnt = 0;
        end else begin
            aw = -1;
            for (int i = 0; i < N; i++) if (req_valid[i] && e_ready[i]) aw = i;
            if (aw >= 0) begin
                m_on = 1; m_start = cyc + 1; m_byte = req_data[8*aw +: 8]; m_tcnt = 0;
                if (req_last[aw]) begin
                    m_owner = -1; m_rr = (aw + 1) % N;
                end else begin
                    m_owner = aw;
                end
            end else if (!in_fr && m_owner >= 0 && !req_valid[m_owner]) begin
                m_tcnt++;
                if (m_tcnt == LT) begin
                    m_rr = (m_owner + 1) % N; m_owner = -1; m_tcnt = 0;
                end
            end else begin
                m_tcnt = 0;
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d, input logic l);
        bit got;
        int n;
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = d;
        req_last[i] = l;
        got = 0;
        n = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (req_ready[i]) got = 1;
        end
        check("send_ready", got, 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        acc_cyc.delete(); acc_idx.delete(); acc_byte.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_acc(input string tag, input int k, input int idx, input int byt,
                             input int gap);
        if (acc_cyc.size() <= k) begin
            check({tag, "_present"}, 0, 1);
            return;
        end
        check({tag, "_idx"}, acc_idx[k], idx);
        check({tag, "_byte"}, acc_byte[k], byt);
        if (k > 0) check({tag, "_gap"}, acc_cyc[k] - acc_cyc[k-1], gap);
    endtask

    logic [9:0] pat;

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single byte 0xA5: start, LSB-first data, stop, four cycles each.
        do_reset();
        pat = {1'b1, 8'hA5, 1'b0};
        send(0, 8'hA5, 1'b1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("t1_txd", uart_txd, pat[k/4]);
            check("t1_busy", busy, 1);
            check("t1_grant", grant, 0);
        end
        @(negedge clk);
        check("t1_end_txd", uart_txd, 1);
        check("t1_end_busy", busy, 0);
        check_acc("t1_a0", 0, 0, 8'hA5, 0);
        @(posedge clk); #1;

        // Packet lock: req1 waits for the whole three-byte req0 packet.
        do_reset();
        fork
            begin
                send(0, 8'h01, 1'b0);
                send(0, 8'h02, 1'b0);
                send(0, 8'h03, 1'b1);
            end
            send(1, 8'h55, 1'b1);
        join
        tick(45);
        check_acc("t2_a0", 0, 0, 8'h01, 0);
        check_acc("t2_a1", 1, 0, 8'h02, 41);
        check_acc("t2_a2", 2, 0, 8'h03, 41);
        check_acc("t2_a3", 3, 1, 8'h55, 41);

        // Round robin with single-byte packets from both.
        do_reset();
        fork
            begin send(0, 8'h10, 1'b1); send(0, 8'h11, 1'b1); end
            begin send(1, 8'h20, 1'b1); send(1, 8'h21, 1'b1); end
        join
        tick(45);
        check_acc("t3_a0", 0, 0, 8'h10, 0);
        check_acc("t3_a1", 1, 1, 8'h20, 41);
        check_acc("t3_a2", 2, 0, 8'h11, 41);
        check_acc("t3_a3", 3, 1, 8'h21, 41);

        // Lock timeout: 41-cycle frame + 8 idle locked cycles before req1 gets in.
        do_reset();
        fork
            send(0, 8'h3C, 1'b0);
            send(1, 8'h77, 1'b1);
        join
        tick(45);
        check_acc("t4_a0", 0, 0, 8'h3C, 0);
        check_acc("t4_a1", 1, 1, 8'h77, 49);

        // Owner returns in the expiry cycle: its byte wins, lock kept.
        do_reset();
        fork
            begin
                send(0, 8'h3C, 1'b0);
                repeat (47) @(posedge clk);
                #1;
                send(0, 8'h5A, 1'b0);
            end
            send(1, 8'h77, 1'b1);
        join
        tick(45);
        check_acc("t5_a0", 0, 0, 8'h3C, 0);
        check_acc("t5_a1", 1, 0, 8'h5A, 48);
        check_acc("t5_a2", 2, 1, 8'h77, 49);

        // Reset during data bit 3 of 0x81 (bit 3 is 0).
        do_reset();
        send(0, 8'h81, 1'b0);
        tick(17);
        reset = 1'b1;
        @(negedge clk);
        check("t6_pre_txd", uart_txd, 0);
        check("t6_pre_busy", busy, 1);
        check("t6_pre_grant", grant, 2'b01);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_post_txd", uart_txd, 1);
        check("t6_post_busy", busy, 0);
        check("t6_post_grant", grant, 0);
        @(posedge clk); #1;
        acc_cyc.delete(); acc_idx.delete(); acc_byte.delete();
        fork
            send(0, 8'h11, 1'b1);
            send(1, 8'h22, 1'b1);
        join
        tick(45);
        check_acc("t6_a0", 0, 0, 8'h11, 0);
        check_acc("t6_a1", 1, 1, 8'h22, 41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
